// File: rtl/wb_mstr_arb2.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin grant held for a whole CYC.
// Optional stall watchdog is built when WB_MSTR_ARB2_WDOG_EN is defined.
module wb_mstr_arb2 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  // One-hot encoding so the state register is the grant vector itself.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [15:0] TO_LIM = 16'(TO_CYCLES);

  state_e state_q, state_d;
  logic   last_q, last_d;

  logic            cyc_mux, stb_mux, we_mux;
  logic [DW/8-1:0] sel_mux;
  logic [AW-1:0]   adr_mux;
  logic [DW-1:0]   dat_mux;
  logic            wd_to;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Slave mux follows the registered grant, so a handover clock always shows CYC low.
  always_comb begin
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    we_mux  = 1'b0;
    sel_mux = '0;
    adr_mux = '0;
    dat_mux = '0;
    case (state_q)
      GNT0: begin
        cyc_mux = m0_cyc_i;
        stb_mux = m0_stb_i;
        we_mux  = m0_we_i;
        sel_mux = m0_sel_i;
        adr_mux = m0_adr_i;
        dat_mux = m0_dat_i;
      end
      GNT1: begin
        cyc_mux = m1_cyc_i;
        stb_mux = m1_stb_i;
        we_mux  = m1_we_i;
        sel_mux = m1_sel_i;
        adr_mux = m1_adr_i;
        dat_mux = m1_dat_i;
      end
      default: ;
    endcase
  end

`ifdef WB_MSTR_ARB2_WDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  assign wd_to = (wd_cnt_q == TO_LIM);

  always_comb begin
    wd_cnt_d = wd_cnt_q + 16'd1;
    if (wd_to || (state_d != state_q) || !stb_mux || s_ack_i || s_err_i)
      wd_cnt_d = '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) wd_cnt_q <= '0;
    else             wd_cnt_q <= wd_cnt_d;
  end
`else
  logic unused_to_lim;
  assign unused_to_lim = ^TO_LIM;
  assign wd_to         = 1'b0;
`endif

  assign s_cyc_o = cyc_mux & ~wd_to;
  assign s_stb_o = stb_mux & ~wd_to;
  assign s_we_o  = we_mux;
  assign s_sel_o = sel_mux;
  assign s_adr_o = adr_mux;
  assign s_dat_o = dat_mux;

  assign gnt_o    = state_q;
  assign m0_ack_o = s_ack_i & state_q[0];
  assign m1_ack_o = s_ack_i & state_q[1];
  assign m0_err_o = (s_err_i | wd_to) & state_q[0];
  assign m1_err_o = (s_err_i | wd_to) & state_q[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_mstr_arb2.sv
// Self-checking bench for wb_mstr_arb2: directed scenarios plus randomized round-robin traffic.
module tb_wb_mstr_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic wb_clk_i = 1'b0;
  logic wb_rst_n_i = 1'b0;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [1:0] gnt_o;

  int vectors = 0;
  int miscompares = 0;
  int model_last = 1;
  logic [AW-1:0] exp_q[$];
  int exp_id_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  wb_mstr_arb2 #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got hang want finish");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive_m(input int x, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (x == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = '1;
      m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = '1;
      m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic idle_inputs();
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    wb_rst_n_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    model_last = 1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1234; m1_cyc_i = 1'b1;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
    vectors++;
    if ({s_cyc_o, s_stb_o, s_adr_o} !== '0) begin
      miscompares++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h want 0", s_cyc_o, s_stb_o, s_adr_o);
    end
    vectors++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0) begin
      miscompares++; $display("FAIL reset_master: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    idle_inputs();
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    tick();
    s_ack_i = 1'b1; s_err_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, gnt_o} !== 6'b0) begin
      miscompares++; $display("FAIL idle_ack_ignored: got %b want 000000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, gnt_o});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_single_read();
    int ack0 = 0, ack1 = 0;
    logic [DW-1:0] rd = '0;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, '0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) begin s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; end
      if (k == 4) begin s_ack_i = 1'b0; drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0); end
      @(negedge wb_clk_i);
      if (k == 1) begin
        vectors++;
        if ({gnt_o, s_cyc_o, s_adr_o} !== {2'b01, 1'b1, 32'h0000_1000}) begin
          miscompares++; $display("FAIL rd_grant: got gnt=%b cyc=%b adr=%h want 01 1 00001000", gnt_o, s_cyc_o, s_adr_o);
        end
      end
      if (m0_ack_o) begin ack0++; rd = m0_dat_o; end
      if (m1_ack_o) ack1++;
    end
    vectors++;
    if (ack0 !== 1) begin miscompares++; $display("FAIL rd_ack_count: got %0d want 1", ack0); end
    vectors++;
    if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    vectors++;
    if (ack1 !== 0) begin miscompares++; $display("FAIL rd_m1_ack: got %0d want 0", ack1); end
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if (gnt_o !== 2'b00) begin miscompares++; $display("FAIL rd_idle: got %b want 00", gnt_o); end
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h1000, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h2000, '0);
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if ({gnt_o, s_adr_o} !== {2'b01, 32'h1000}) begin
      miscompares++; $display("FAIL tie_first: got gnt=%b adr=%h want 01 00001000", gnt_o, s_adr_o);
    end
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      miscompares++; $display("FAIL tie_ack0: got m0=%b m1=%b want 1 0", m0_ack_o, m1_ack_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge wb_clk_i);
    vectors++;
    if (s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL tie_handover: got s_cyc=%b want 0", s_cyc_o); end
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if ({gnt_o, s_cyc_o, s_adr_o} !== {2'b10, 1'b1, 32'h2000}) begin
      miscompares++; $display("FAIL tie_second: got gnt=%b cyc=%b adr=%h want 10 1 00002000", gnt_o, s_cyc_o, s_adr_o);
    end
    tick();
    s_ack_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if ({m0_ack_o, m1_ack_o} !== 2'b01) begin
      miscompares++; $display("FAIL tie_ack1: got m0=%b m1=%b want 0 1", m0_ack_o, m1_ack_o);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    int ack0 = 0, ack1 = 0;
    logic [DW-1:0] wd;
    do_reset();
    drive_m(0, 1'b1, 1'b0, 1'b1, 32'h3000, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h4000, '0);
    tick();
    for (int b = 0; b < 4; b++) begin
      wd = $urandom;
      drive_m(0, 1'b1, 1'b1, 1'b1, 32'h3000 + 32'(4 * b), wd);
      s_ack_i = 1'b1;
      @(negedge wb_clk_i);
      vectors++;
      if ({gnt_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== {2'b01, 1'b1, 4'hf, 32'h3000 + 32'(4 * b), wd}) begin
        miscompares++;
        $display("FAIL burst_beat%0d: got gnt=%b we=%b sel=%h adr=%h dat=%h want 01 1 f %h %h",
                 b, gnt_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, 32'h3000 + 32'(4 * b), wd);
      end
      if (m0_ack_o) ack0++;
      if (m1_ack_o) ack1++;
      tick();
      m0_stb_i = 1'b0;
      s_ack_i = 1'b0;
      @(negedge wb_clk_i);
      vectors++;
      if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL burst_hold%0d: got %b want 01", b, gnt_o); end
      tick();
    end
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge wb_clk_i);
    vectors++;
    if (s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL burst_handover: got s_cyc=%b want 0", s_cyc_o); end
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if ({gnt_o, s_adr_o} !== {2'b10, 32'h4000}) begin
      miscompares++; $display("FAIL burst_m1_grant: got gnt=%b adr=%h want 10 00004000", gnt_o, s_adr_o);
    end
    vectors++;
    if ({ack0, ack1} !== {32'd4, 32'd0}) begin
      miscompares++; $display("FAIL burst_acks: got m0=%0d m1=%0d want 4 0", ack0, ack1);
    end
    tick();
    s_ack_i = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  // Randomized traffic: each master issues n[x] single-beat cycles; the slave acks after a random delay.
  task automatic run_traffic(input int n0, input int n1);
    int n[2], rem[2], idx[2], cur, wait_cnt, lat, id;
    logic act[2], got[2], seen_stb, done;
    logic [AW-1:0] addr[2][8], ea;
    n[0] = n0; n[1] = n1;
    for (int x = 0; x < 2; x++) begin
      rem[x] = n[x]; idx[x] = 0; act[x] = 1'b0; got[x] = 1'b0;
      for (int i = 0; i < 8; i++) addr[x][i] = {$urandom_range(0, 16'hffff), 14'h0, x[0], 1'b0} ;
    end
    while (rem[0] > 0 || rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) cur = model_last ^ 1;
      else cur = (rem[0] > 0) ? 0 : 1;
      exp_q.push_back(addr[cur][n[cur] - rem[cur]]);
      exp_id_q.push_back(cur);
      rem[cur]--;
      model_last = cur;
    end
    wait_cnt = 0; lat = $urandom_range(0, 2); seen_stb = 1'b0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (act[x] && got[x]) begin
          act[x] = 1'b0; idx[x]++;
          drive_m(x, 1'b0, 1'b0, 1'b0, '0, '0);
        end else if (!act[x] && idx[x] < n[x]) begin
          act[x] = 1'b1;
          drive_m(x, 1'b1, 1'b1, 1'b0, addr[x][idx[x]], $urandom);
        end
      end
      if (s_ack_i) s_ack_i = 1'b0;
      else if (seen_stb && wait_cnt > lat) begin
        s_ack_i = 1'b1; s_dat_i = $urandom; wait_cnt = 0; lat = $urandom_range(0, 2);
      end
      done = !act[0] && !act[1] && idx[0] == n[0] && idx[1] == n[1];
      @(negedge wb_clk_i);
      got[0] = m0_ack_o; got[1] = m1_ack_o;
      if (s_ack_i) begin
        vectors++;
        if (got[0] == got[1] || exp_q.size() == 0) begin
          miscompares++; $display("FAIL traffic_route: got m0_ack=%b m1_ack=%b want exactly one", got[0], got[1]);
        end else begin
          id = got[0] ? 0 : 1;
          ea = exp_q.pop_front();
          cur = exp_id_q.pop_front();
          if (id !== cur || s_adr_o !== ea || (id == 0 ? m0_dat_o : m1_dat_o) !== s_dat_i) begin
            miscompares++;
            $display("FAIL traffic_order: got master %0d adr=%h want master %0d adr=%h", id, s_adr_o, cur, ea);
          end
        end
      end
      seen_stb = s_cyc_o & s_stb_o & ~s_ack_i;
      if (seen_stb) wait_cnt++;
      if (!done) tick();
    end
    vectors++;
    if (!done || exp_q.size() != 0) begin
      miscompares++; $display("FAIL traffic_complete: got %0d pending want 0 (done=%b)", exp_q.size(), done);
    end
    exp_q.delete(); exp_id_q.delete();
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_traffic(3, 3);
    for (int r = 0; r < 4; r++) run_traffic($urandom_range(1, 5), $urandom_range(1, 5));
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0100, '0);
    tick();
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    drive_m(1, 1'b1, 1'b1, 1'b1, 32'h5000, 32'h55);
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if (gnt_o !== 2'b10) begin miscompares++; $display("FAIL mid_pre_gnt: got %b want 10", gnt_o); end
    tick();
    s_ack_i = 1'b1;
    #3;
    wb_rst_n_i = 1'b0;
    #1;
    vectors++;
    if ({gnt_o, s_cyc_o, m1_ack_o} !== 4'b0) begin
      miscompares++; $display("FAIL mid_reset: got gnt=%b cyc=%b m1_ack=%b want 00 0 0", gnt_o, s_cyc_o, m1_ack_o);
    end
    idle_inputs();
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    model_last = 1;
    tick();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h0200, '0);
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h0300, '0);
    tick();
    @(negedge wb_clk_i);
    vectors++;
    if ({gnt_o, s_adr_o} !== {2'b01, 32'h0200}) begin
      miscompares++; $display("FAIL mid_tie_after: got gnt=%b adr=%h want 01 00000200", gnt_o, s_adr_o);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int stalled = 0;
    logic err_seen = 1'b0;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h6000, '0);
    tick();
    for (int k = 0; k < 40 && !err_seen; k++) begin
      @(negedge wb_clk_i);
      if (m0_err_o) begin
        err_seen = 1'b1;
        vectors++;
        if ({s_stb_o, s_cyc_o, m1_err_o, gnt_o} !== {3'b000, 2'b01}) begin
          miscompares++; $display("FAIL wdog_pulse: got stb=%b cyc=%b m1_err=%b gnt=%b want 0 0 0 01", s_stb_o, s_cyc_o, m1_err_o, gnt_o);
        end
      end else if (s_stb_o) stalled++;
      tick();
    end
`ifdef WB_MSTR_ARB2_WDOG_EN
    vectors++;
    if ({err_seen, stalled} !== {1'b1, TO}) begin
      miscompares++; $display("FAIL wdog_count: got err=%b stalled=%0d want 1 %0d", err_seen, stalled, TO);
    end
    @(negedge wb_clk_i);
    vectors++;
    if ({m0_err_o, s_stb_o, gnt_o} !== {2'b01, 2'b01}) begin
      miscompares++; $display("FAIL wdog_after: got err=%b stb=%b gnt=%b want 0 1 01", m0_err_o, s_stb_o, gnt_o);
    end
`else
    vectors++;
    if ({err_seen, stalled} !== {1'b0, 32'd40}) begin
      miscompares++; $display("FAIL wdog_absent: got err=%b stalled=%0d want 0 40", err_seen, stalled);
    end
`endif
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_mstr_arb2.md
Name: wb_mstr_arb2

Overview:
- Two-master, one-slave Wishbone classic arbiter in front of the shared system memory slave.
- Master 0 is the Ethernet MAC DMA master port (m_wb_*); master 1 is the host/CPU data master.
- Round-robin grant; the grant is held for the whole bus cycle (CYC high), so MAC descriptor/buffer bursts are never split.
- Provides per-master ack/err return, a grant status vector, and an optional stall watchdog.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width; SEL width is DW/8.
- TO_CYCLES, 255, watchdog limit in clocks: STB high with no ACK/ERR (used only with the optional feature); legal range 2..65535.

Ports:
- wb_clk_i  in  1  bus clock; all state is on the rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel_i  in  DW/8  master 0 byte selects.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge and error.
- m1_*  same set, directions and widths as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe and write enable.
- s_sel_o  out  DW/8  slave byte selects.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i, s_err_i  in  1 each  slave acknowledge and error.
- gnt_o  out  2  one-hot current grant; 00 = idle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, gnt_o = 00, last-served pointer = 1 (master 0 wins the first tie).
  - Watchdog counter = 0.
  - All slave-side and master-side outputs are 0 while reset is asserted and in IDLE.
- FSM states: IDLE, GNT0, GNT1. The state register drives gnt_o directly.
- IDLE:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not last-served.
  - Neither high -> stay in IDLE.
  - Grant latency: request sampled at edge N; s_cyc_o is high from edge N onward. One clock from CYC rise to slave CYC.
- GNTx:
  - Stay while mx_cyc_i = 1; STB may toggle freely inside the cycle.
  - When mx_cyc_i = 0: set last-served = x. If the other master's CYC is high, go directly to GNTy; otherwise go to IDLE.
  - During the handover clock s_cyc_o = 0, because the slave mux follows the new grant only from the next edge. This guarantees at least one idle clock between cycles from different masters.
- Slave mux (combinational from the registered grant):
  - In GNTx: s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i; s_we_o, s_sel_o, s_adr_o and s_dat_o are taken from master x.
  - In IDLE: all slave outputs are 0.
- Return path:
  - mx_ack_o = s_ack_i & gnt_o[x]; mx_err_o = s_err_i & gnt_o[x].
  - A non-granted master never sees ACK or ERR.
  - m0_dat_o = m1_dat_o = s_dat_i (broadcast; only meaningful alongside ack).
- Simultaneous events:
  - Granted master drops CYC on the same edge the other master raises CYC -> the other master is granted at that edge.
  - Both masters request continuously -> strict alternation, one cycle each.
- Reset mid-cycle: the grant drops immediately (asynchronous); the slave sees CYC fall and the master sees no ack.
- An ACK/ERR from the slave while in IDLE is ignored.

Optional Feature:
- Macro: WB_MSTR_ARB2_WDOG_EN.
- Defined:
  - A 16-bit counter increments each clock with s_stb_o = 1 and s_ack_i = s_err_i = 0.
  - The counter clears on ACK, on ERR, on STB low, or on a grant change.
  - When the count reaches TO_CYCLES: the arbiter drives mx_err_o = 1 for one clock, forces s_cyc_o = s_stb_o = 0 for that clock, and clears the counter. The grant is kept until the master drops CYC.
- Undefined: no counter is built; ERR is pure pass-through and a hung slave stalls the granted master indefinitely.

Test Plan:
- m0 single read, addr 0x0000_1000, slave acks on the 3rd clock with data 0xDEAD_BEEF -> gnt_o = 01; m0_ack_o pulses once with m0_dat_o = 0xDEAD_BEEF; m1_ack_o stays 0.
- m0 and m1 raise CYC on the same edge just after reset -> m0 is granted first. After m0 drops CYC: one clock with s_cyc_o = 0, then gnt_o = 10 and m1's address 0x2000 appears on s_adr_o.
- m0 holds CYC across a 4-beat write burst while m1 requests -> m1 is not granted until m0's CYC falls; exactly 4 slave acks, all routed to m0.
- Both masters request continuously for 6 single-beat cycles -> grant order 0,1,0,1,0,1.
- Assert wb_rst_n_i low mid-burst while in GNT1 -> gnt_o = 00 and s_cyc_o = 0 immediately (same clock, asynchronous). After release, the next tie goes to m0.
- WB_MSTR_ARB2_WDOG_EN defined, TO_CYCLES = 8, slave never acks -> exactly 8 stalled clocks, then m0_err_o pulses for 1 clock with s_stb_o = 0. Without the macro, the same stimulus produces no err pulse.
